// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer between the UART bit receiver and the
// word-assembly controller; registered fill level, flags and overflow pulse.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  ovf_q, ovf_d;
    logic                  we, re;

    // A pop in the same cycle frees a slot, so a write at full is still accepted.
    assign we = wr & (~full_q | rd);
    assign re = rd & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (we) wr_ptr_d = wr_ptr_q + 1'b1;
        if (re) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({we, re})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_CNT);
        ovf_d   = wr & full_q & ~rd;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (rst && we) mem_q[wr_ptr_q] <= w_data;
    end

    assign r_data   = mem_q[rd_ptr_q];
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst, wr, rd;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       empty, full, overflow;
    logic [4:0] count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mq[$];
    logic       m_ovf;

    uart_rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data), .empty(empty), .full(full), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the FIFO rules, compare.
    task automatic cyc(input logic r, input logic w, input logic p, input logic [7:0] d);
        bit m_full, m_empty;
        rst = r; wr = w; rd = p; w_data = d;
        @(posedge clk);
        m_full  = (mq.size() == 16);
        m_empty = (mq.size() == 0);
        if (!r) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_ovf = w && m_full && !p;
            if (p && !m_empty) void'(mq.pop_front());
            if (w && (!m_full || p)) mq.push_back(d);
        end
        #1;
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full", 32'(full), 32'(mq.size() == 16));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) chk("r_data", 32'(r_data), 32'(mq[0]));
        rst = 1'b1; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
    endtask

    initial begin
        m_ovf = 1'b0;
        rst = 1'b0; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
        // reset held with a pending write
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("rst_empty", 32'(empty), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("idle_empty", 32'(empty), 32'd1);

        // FWFT ordering
        cyc(1'b1, 1'b1, 1'b0, 8'h12);
        chk("fwft_head", 32'(r_data), 32'h12);
        cyc(1'b1, 1'b1, 1'b0, 8'h34);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        chk("fwft_second", 32'(r_data), 32'h34);
        chk("fwft_cnt", 32'(count), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);
        chk("fwft_drained", 32'(empty), 32'd1);

        // fill, overflow, drain
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0, 8'(i));
        chk("fill_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 8'hFF);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_cnt", 32'(count), 32'd16);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("ovf_one_cycle", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 32'(r_data), 32'(i));
            cyc(1'b1, 1'b0, 1'b1, 8'h00);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // simultaneous write and pop at full
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0, 8'(i));
        cyc(1'b1, 1'b1, 1'b1, 8'h55);
        chk("sim_cnt", 32'(count), 32'd16);
        chk("sim_no_ovf", 32'(overflow), 32'd0);
        chk("sim_head", 32'(r_data), 32'h01);
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
        chk("sim_tail", 32'(r_data), 32'h55);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);

        // read on empty
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
        chk("rdempty_cnt", 32'(count), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 8'h77);
        chk("rdempty_head", 32'(r_data), 32'h77);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);

        // reset mid-stream
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
        cyc(1'b0, 1'b1, 1'b1, 8'hEE);
        chk("midrst_empty", 32'(empty), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 8'h9C);
        chk("midrst_head", 32'(r_data), 32'h9C);
        chk("midrst_cnt", 32'(count), 32'd1);

        // random traffic with shifting write/read bias to reach both extremes
        for (int i = 0; i < 3000; i++) begin
            int wp, rp;
            wp = ((i / 300) % 2 == 0) ? 70 : 30;
            rp = 100 - wp;
            cyc(($urandom_range(0, 399) != 0),
                ($urandom_range(0, 99) < wp),
                ($urandom_range(0, 99) < rp),
                8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
